// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall with configurable latency, mult/div
// busy tracking for HI/LO readers, taken-branch IF/ID flush and a stall counter.
module hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int MD_LAT   = 8,
    parameter int PERF_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_uses_hilo,
    input  logic              id_branch_taken,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_is_load,
    input  logic              ex_md_start,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic              md_busy,
    output logic [PERF_W-1:0] stall_cycles
);
    localparam int LD_W = $clog2(LOAD_LAT + 1);
    localparam int MD_W = $clog2(MD_LAT + 1);
    localparam logic [LD_W-1:0] LD_RELOAD = LD_W'(LOAD_LAT - 1);
    localparam logic [MD_W-1:0] MD_RELOAD = MD_W'(MD_LAT);

    logic [LD_W-1:0]   ld_cnt_q, ld_cnt_d;
    logic [MD_W-1:0]   md_cnt_q, md_cnt_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic              load_hit, ld_hold, md_active, stall;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == {PERF_W{1'b1}}) ? v : v + PERF_W'(1);
    endfunction

    // Hazard detection; every term is masked while reset is held
    always_comb begin
        load_hit  = ~rst & ex_is_load & (ex_rd != '0) &
                    ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
        ld_hold   = ~rst & (ld_cnt_q != '0);
        md_active = ~rst & (md_cnt_q != '0);
        stall     = load_hit | ld_hold | (md_active & id_uses_hilo);
    end

    always_comb begin
        ld_cnt_d = ld_cnt_q;
        if (load_hit && (ld_cnt_q == '0)) begin
            ld_cnt_d = LD_RELOAD;
        end else if (ld_cnt_q != '0) begin
            ld_cnt_d = ld_cnt_q - LD_W'(1);
        end

        // A new issue restarts the busy window even if one is in flight
        md_cnt_d = md_cnt_q;
        if (ex_md_start) begin
            md_cnt_d = MD_RELOAD;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - MD_W'(1);
        end

        stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_cnt_q    <= '0;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            ld_cnt_q    <= ld_cnt_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Stall beats flush: a branch behind a hazard is re-resolved once released
    always_comb begin
        pc_write     = ~stall;
        ifid_write   = ~stall;
        idex_bubble  = stall;
        ifid_flush   = id_branch_taken & ~stall;
        md_busy      = md_active;
        stall_cycles = stall_cnt_q;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage MIPS core, sitting between ID/EX decode signals and the PC, IF/ID and ID/EX pipeline registers. It generalises single-cycle load-use detection to a configurable load-use latency, adds a multiply/divide busy tracker that stalls HI/LO readers, and adds taken-branch flush of IF/ID. It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- REG_AW, 5: register-address width.
- LOAD_LAT, 1: load-use bubble cycles, ≥1.
- MD_LAT, 8: mult/div busy cycles after issue, ≥1.
- PERF_W, 16: stall counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  REG_AW  rs of the instruction in ID.
- id_rt  in  REG_AW  rt of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_uses_hilo  in  1  ID instruction reads HI/LO or is mult/div.
- id_branch_taken  in  1  branch/jump resolved taken in ID.
- ex_rd  in  REG_AW  destination register of the instruction in EX.
- ex_is_load  in  1  EX instruction is LW.
- ex_md_start  in  1  mult/div issuing in EX this cycle.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register enable.
- idex_bubble  out  1  zero ID/EX control signals (insert NOP).
- ifid_flush  out  1  clear IF/ID (squash fetched instruction).
- md_busy  out  1  mult/div unit busy.
- stall_cycles  out  PERF_W  saturating count of stall cycles.

## Operation
- load_hit = ex_is_load & (ex_rd != 0) & ((id_uses_rs & id_rs == ex_rd) | (id_uses_rt & id_rt == ex_rd)). Register $0 never hazards.
- ld_cnt, width clog2(LOAD_LAT+1): when load_hit & ld_cnt==0, load LOAD_LAT-1. Otherwise, when non-zero, decrement.
- md_cnt, width clog2(MD_LAT+1): ex_md_start loads MD_LAT, including when already busy (reload). Otherwise, when non-zero, decrement. md_busy = (md_cnt != 0).
- stall = load_hit | (ld_cnt != 0) | (md_busy & id_uses_hilo).
- While stalled: pc_write=0, ifid_write=0, idex_bubble=1.
- ifid_flush = id_branch_taken & ~stall. Stall has priority: a branch in ID with an unresolved hazard is held and re-resolved when released.
- stall_cycles increments by 1 every stalled cycle and saturates at 2^PERF_W-1.
- While rst=1: all hazard terms are masked. Outputs are pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0, md_busy=0. On the next edge ld_cnt=0, md_cnt=0, stall_cycles=0.

## Timing
- Detection is combinational: outputs respond in the same cycle as load_hit, id_uses_hilo or id_branch_taken.
- Load-use stall lasts exactly LOAD_LAT cycles. Cycle 0 is load_hit. Cycles 1..LOAD_LAT-1 are held by ld_cnt after the load has left EX. With LOAD_LAT=1 the stall is single-cycle and purely combinational.
- ex_md_start at cycle t gives md_busy=1 in cycles t+1..t+MD_LAT. A HI/LO reader sitting in ID from t+1 stalls MD_LAT cycles and advances at t+MD_LAT+1.
- Simultaneous load_hit and md stall: one combined stall. Each counter runs independently and the stall ends when both causes clear.
- Reset mid-stall: stall and md_busy drop in the reset cycle. Counters are 0 after the edge.

## Test plan
- LOAD_LAT=1: ex_is_load=1, ex_rd=8, id_rs=8, id_uses_rs=1 for one cycle, then ex_is_load=0 -> stall exactly 1 cycle (pc_write=0, ifid_write=0, idex_bubble=1); stall_cycles=1.
- LOAD_LAT=3, same stimulus, load leaves EX after 1 cycle -> stall for cycles 0,1,2, released in cycle 3; stall_cycles=3. Repeat with ex_rd=0 or id_uses_rs=0 -> no stall.
- MD_LAT=8: ex_md_start pulse at t, id_uses_hilo=1 from t+1 -> md_busy and stall high for t+1..t+8, both low at t+9. With id_uses_hilo=0, md_busy still high t+1..t+8 and no stall.
- id_branch_taken=1 with no hazard -> ifid_flush=1, pc_write=1. The same cycle with load_hit -> ifid_flush=0, stall=1. Next cycle, hazard cleared -> ifid_flush=1.
- rst asserted during a LOAD_LAT=3 stall (cycle 1) and a busy md_cnt -> outputs at reset values that cycle; after release with idle inputs there is no stall, md_busy=0, stall_cycles=0.
- PERF_W=4: hold id_uses_hilo=1 with repeated ex_md_start for 20 cycles -> stall_cycles saturates at 15.
